whackamole_game_ctrl: RTL and testbench

//  Game sequencer for whack-a-mole. Picks mole holes with an internal LFSR and times how long each mole

---
 rtl/whackamole_pkg.sv | 23 ++
 rtl/bcd_score_counter.sv | 51 +++++
 rtl/whackamole_game_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_whackamole_game_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/whackamole_pkg.sv
// Shared constants for the whack-a-mole game sequencer.
//   NO_MOLE : mole_position value meaning no hole is lit
//   BCD_MAX : saturation value of the two-digit BCD score
//   IDLE..OVER : game FSM state encodings
package whackamole_pkg;

    localparam int unsigned POS_W   = 3;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [POS_W-1:0]     NO_MOLE = 3'd7;
    localparam logic [2*DIGIT_W-1:0] BCD_MAX = 8'h99;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t SPAWN = 3'd1;
    localparam state_t UP    = 3'd2;
    localparam state_t HIT   = 3'd3;
    localparam state_t MISS  = 3'd4;
    localparam state_t OVER  = 3'd5;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter, saturating at 99.
//   master_clk, rst : clock, async active-low reset
//   inc_i           : add one to the score (ignored at 99)
//   clr_i           : clear the score (wins over inc_i)
//   digit_1_o       : tens digit
//   digit_2_o       : units digit
module bcd_score_counter
    import whackamole_pkg::*;
(
    input  logic               master_clk,
    input  logic               rst,
    input  logic               inc_i,
    input  logic               clr_i,
    output logic [DIGIT_W-1:0] digit_1_o,
    output logic [DIGIT_W-1:0] digit_2_o
);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] units_q, units_d;

    // Units roll 9->0 with a carry into tens; hold once both digits read 9.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr_i) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc_i && ({tens_q, units_q} != BCD_MAX)) begin
            if (units_q == DIGIT_W'(9)) begin
                units_d = '0;
                tens_d  = tens_q + DIGIT_W'(1);
            end else begin
                units_d = units_q + DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign digit_1_o = tens_q;
    assign digit_2_o = units_q;

endmodule

// File: rtl/whackamole_game_ctrl.sv
// Whack-a-mole game sequencer: LFSR mole placement, mole/feedback timing,
// hit judging and BCD scoring.
//   master_clk, rst            : clock, async active-low reset
//   tick_game                  : one-cycle game-time enable
//   start                      : one-cycle start pulse
//   btn_valid, btn_index       : one-cycle hit pulse and the hole pressed
//   mole_position              : lit hole, NO_MOLE when none
//   guess_correct, guess_wrong : hit / miss feedback windows
//   digit_1, digit_2           : score tens / units, BCD
//   game_over                  : high while the game is over
module whackamole_game_ctrl
    import whackamole_pkg::*;
#(
    parameter int unsigned NUM_HOLES   = 6,
    parameter int unsigned MOLE_TICKS  = 4,
    parameter int unsigned FLASH_TICKS = 2,
    parameter int unsigned MAX_MISSES  = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               master_clk,
    input  logic               rst,
    input  logic               tick_game,
    input  logic               start,
    input  logic               btn_valid,
    input  logic [POS_W-1:0]   btn_index,
    output logic [POS_W-1:0]   mole_position,
    output logic               guess_correct,
    output logic               guess_wrong,
    output logic [DIGIT_W-1:0] digit_1,
    output logic [DIGIT_W-1:0] digit_2,
    output logic               game_over
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] UP_LAST    = CNT_W'(MOLE_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);
    localparam logic [CNT_W-1:0] MISS_END   = CNT_W'(MAX_MISSES);

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [POS_W-1:0]   mole_q, mole_d;
    logic [POS_W-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic               gc_q, gc_d;
    logic               gw_q, gw_d;
    logic               go_q, go_d;

    logic [POS_W-1:0]   cand_c;
    logic               cand_ok_c;
    logic               btn_match_c;
    logic               score_inc_c;
    logic               score_clr_c;

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
    assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand_c      = lfsr_q[POS_W-1:0];
    assign cand_ok_c   = (32'(cand_c) < NUM_HOLES) && (cand_c != prev_q);
    assign btn_match_c = (btn_index == mole_q);

    // State register and all registered datapath/outputs.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            mole_q  <= NO_MOLE;
            prev_q  <= NO_MOLE;
            tick_q  <= '0;
            miss_q  <= '0;
            gc_q    <= 1'b0;
            gw_q    <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mole_q  <= mole_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
            miss_q  <= miss_d;
            gc_q    <= gc_d;
            gw_q    <= gw_d;
            go_q    <= go_d;
        end
    end

    // Next-state logic; a button press in UP takes priority over a timeout tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = SPAWN;
            SPAWN: if (cand_ok_c) state_d = UP;
            UP: begin
                if (btn_valid)                           state_d = btn_match_c ? HIT : MISS;
                else if (tick_game && tick_q == UP_LAST) state_d = MISS;
            end
            HIT:   if (tick_game && tick_q == FLASH_LAST) state_d = SPAWN;
            MISS: begin
                if (tick_game && tick_q == FLASH_LAST)
                    state_d = (miss_q == MISS_END) ? OVER : SPAWN;
            end
            OVER:  if (start) state_d = SPAWN;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values, mirroring the transitions above.
    always_comb begin
        mole_d      = mole_q;
        prev_d      = prev_q;
        tick_d      = tick_q;
        miss_d      = miss_q;
        gc_d        = gc_q;
        gw_d        = gw_q;
        go_d        = go_q;
        score_inc_c = 1'b0;
        score_clr_c = 1'b0;
        case (state_q)
            IDLE: begin
                mole_d = NO_MOLE;
                if (start) begin
                    score_clr_c = 1'b1;
                    miss_d      = '0;
                    go_d        = 1'b0;
                end
            end
            SPAWN: begin
                if (cand_ok_c) begin
                    mole_d = cand_c;
                    prev_d = cand_c;
                    tick_d = '0;
                end
            end
            UP: begin
                if (btn_valid) begin
                    mole_d = NO_MOLE;
                    tick_d = '0;
                    if (btn_match_c) begin
                        gc_d        = 1'b1;
                        score_inc_c = 1'b1;
                    end else begin
                        gw_d   = 1'b1;
                        miss_d = miss_q + CNT_W'(1);
                    end
                end else if (tick_game) begin
                    if (tick_q == UP_LAST) begin
                        mole_d = NO_MOLE;
                        tick_d = '0;
                        gw_d   = 1'b1;
                        miss_d = miss_q + CNT_W'(1);
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
            end
            HIT: begin
                mole_d = NO_MOLE;
                if (tick_game) begin
                    if (tick_q == FLASH_LAST) begin
                        gc_d   = 1'b0;
                        tick_d = '0;
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
            end
            MISS: begin
                mole_d = NO_MOLE;
                if (tick_game) begin
                    if (tick_q == FLASH_LAST) begin
                        gw_d   = 1'b0;
                        tick_d = '0;
                        if (miss_q == MISS_END) go_d = 1'b1;
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
            end
            OVER: begin
                mole_d = NO_MOLE;
                go_d   = 1'b1;
                if (start) begin
                    score_clr_c = 1'b1;
                    miss_d      = '0;
                    go_d        = 1'b0;
                end
            end
            default: mole_d = NO_MOLE;
        endcase
    end

    bcd_score_counter u_score (
        .master_clk (master_clk),
        .rst        (rst),
        .inc_i      (score_inc_c),
        .clr_i      (score_clr_c),
        .digit_1_o  (digit_1),
        .digit_2_o  (digit_2)
    );

    assign mole_position = mole_q;
    assign guess_correct = gc_q;
    assign guess_wrong   = gw_q;
    assign game_over     = go_q;

endmodule

// File: tb/tb_whackamole_game_ctrl.sv
// Scoreboarded bench for whackamole_game_ctrl: the driver pushes the expected
// hit/miss/over event, the monitor pops it when the matching output rises.
module tb_whackamole_game_ctrl;

    localparam int EV_HIT  = 0;
    localparam int EV_MISS = 1;
    localparam int EV_OVER = 2;

    typedef struct {
        int         kind;
        logic [3:0] d1;
        logic [3:0] d2;
    } exp_t;

    logic       master_clk = 1'b0;
    logic       rst        = 1'b0;
    logic       tick_game  = 1'b0;
    logic       start      = 1'b0;
    logic       btn_valid  = 1'b0;
    logic [2:0] btn_index  = 3'd0;
    logic [2:0] mole_position;
    logic       guess_correct;
    logic       guess_wrong;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic       game_over;

    exp_t       exp_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    int         score  = 0;
    logic [2:0] last_pos = 3'd7;
    logic       p_gc = 1'b0, p_gw = 1'b0, p_go = 1'b0;

    always #5 master_clk = ~master_clk;

    whackamole_game_ctrl #(
        .NUM_HOLES   (6),
        .MOLE_TICKS  (4),
        .FLASH_TICKS (2),
        .MAX_MISSES  (3),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .master_clk    (master_clk),
        .rst           (rst),
        .tick_game     (tick_game),
        .start         (start),
        .btn_valid     (btn_valid),
        .btn_index     (btn_index),
        .mole_position (mole_position),
        .guess_correct (guess_correct),
        .guess_wrong   (guess_wrong),
        .digit_1       (digit_1),
        .digit_2       (digit_2),
        .game_over     (game_over)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input int kind);
        exp_t e;
        e.kind = kind;
        e.d1   = 4'(score / 10);
        e.d2   = 4'(score % 10);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, return at the next negedge with inputs idle.
    task automatic step(input logic t, input logic s, input logic bv, input logic [2:0] bi);
        tick_game = t;
        start     = s;
        btn_valid = bv;
        btn_index = bi;
        @(negedge master_clk);
        tick_game = 1'b0;
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_index = 3'd0;
    endtask

    task automatic wait_up(output logic [2:0] pos);
        bit seen = 1'b0;
        pos = 3'd7;
        for (int i = 0; i < 300; i++) begin
            if (mole_position != 3'd7) begin
                seen = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 1'b0, 3'd0);
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL spawn_timeout: mole_position still %0d after 300 cycles", mole_position);
        end else begin
            pos = mole_position;
            chk("pos_in_range", int'(pos < 3'd6), 1);
            chk("pos_not_repeat", int'(pos != last_pos), 1);
            last_pos = pos;
        end
    endtask

    task automatic do_hit(input logic [2:0] pos);
        score = (score < 99) ? score + 1 : 99;
        push(EV_HIT);
        step(1'b0, 1'b0, 1'b1, pos);
    endtask

    // Two feedback ticks; a button press during the first one must be ignored.
    task automatic flash(input bit is_hit, input bit ends_game, input logic [2:0] pos);
        step(1'b1, 1'b0, 1'b1, pos);
        chk(is_hit ? "gc_held" : "gw_held", int'(is_hit ? guess_correct : guess_wrong), 1);
        chk("flash_mole_off", int'(mole_position), 7);
        if (ends_game) push(EV_OVER);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        chk(is_hit ? "gc_drop" : "gw_drop", int'(is_hit ? guess_correct : guess_wrong), 0);
    endtask

    // Four ticks without a press; start on the first tick must be ignored.
    task automatic timeout(input logic [2:0] pos);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        chk("up_hold_t1", int'(mole_position), int'(pos));
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        chk("up_hold_t3", int'(mole_position), int'(pos));
        chk("no_early_miss", int'(guess_wrong), 0);
        push(EV_MISS);
        step(1'b1, 1'b0, 1'b0, 3'd0);
    endtask

    // Monitor: pop and compare on each rising feedback / game_over edge.
    always @(negedge master_clk) begin
        if (rst) begin
            if ((guess_correct && !p_gc) || (guess_wrong && !p_gw) || (game_over && !p_go)) begin
                int kind;
                exp_t e;
                kind = (guess_correct && !p_gc) ? EV_HIT : ((guess_wrong && !p_gw) ? EV_MISS : EV_OVER);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_event: got kind %0d with none expected", kind);
                end else begin
                    e = exp_q.pop_front();
                    if (kind != e.kind || digit_1 != e.d1 || digit_2 != e.d2 ||
                        (kind == EV_OVER && mole_position != 3'd7)) begin
                        n_miss++;
                        $display("FAIL event: got kind %0d score %0d%0d mole %0d, expected kind %0d score %0d%0d",
                                 kind, digit_1, digit_2, mole_position, e.kind, e.d1, e.d2);
                    end
                end
            end
        end
        p_gc = guess_correct;
        p_gw = guess_wrong;
        p_go = game_over;
    end

    initial begin
        logic [2:0] pos;
        logic [2:0] wrong;

        @(negedge master_clk);
        chk("rst_mole", int'(mole_position), 7);
        chk("rst_gc", int'(guess_correct), 0);
        chk("rst_gw", int'(guess_wrong), 0);
        chk("rst_d1", int'(digit_1), 0);
        chk("rst_d2", int'(digit_2), 0);
        chk("rst_go", int'(game_over), 0);
        rst = 1'b1;

        // IDLE ignores ticks and buttons
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 3'd2);
        chk("idle_mole", int'(mole_position), 7);
        chk("idle_gc", int'(guess_correct), 0);
        chk("idle_go", int'(game_over), 0);

        // Game 1
        step(1'b0, 1'b1, 1'b0, 3'd0);
        chk("start_d1", int'(digit_1), 0);
        chk("start_d2", int'(digit_2), 0);

        wait_up(pos); do_hit(pos); flash(1'b1, 1'b0, pos);
        chk("hit1_d2", int'(digit_2), 1);

        wait_up(pos);
        wrong = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
        push(EV_MISS);
        step(1'b0, 1'b0, 1'b1, wrong);
        flash(1'b0, 1'b0, pos);

        wait_up(pos); timeout(pos); flash(1'b0, 1'b0, pos);

        // Correct press on the same cycle as the fourth tick counts as a hit
        wait_up(pos);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'd0);
        score = score + 1;
        push(EV_HIT);
        step(1'b1, 1'b0, 1'b1, pos);
        chk("tick_btn_not_miss", int'(guess_wrong), 0);
        flash(1'b1, 1'b0, pos);

        wait_up(pos); timeout(pos); flash(1'b0, 1'b1, pos);
        chk("over_go", int'(game_over), 1);
        chk("over_mole", int'(mole_position), 7);

        // OVER ignores ticks and buttons; score frozen
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 3'd0);
        chk("over_hold_go", int'(game_over), 1);
        chk("over_hold_d2", int'(digit_2), 2);

        // Game 2: restart clears score, then 200 hits to saturation
        step(1'b0, 1'b1, 1'b0, 3'd0);
        score = 0;
        chk("restart_go", int'(game_over), 0);
        chk("restart_d1", int'(digit_1), 0);
        chk("restart_d2", int'(digit_2), 0);
        for (int n = 0; n < 200; n++) begin
            wait_up(pos);
            do_hit(pos);
            if (score == 10) begin
                chk("carry_d1", int'(digit_1), 1);
                chk("carry_d2", int'(digit_2), 0);
            end
            flash(1'b1, 1'b0, pos);
        end
        chk("sat_d1", int'(digit_1), 9);
        chk("sat_d2", int'(digit_2), 9);

        // Asynchronous reset while a mole is up
        wait_up(pos);
        #2 rst = 1'b0;
        #1;
        chk("arst_mole", int'(mole_position), 7);
        chk("arst_d1", int'(digit_1), 0);
        chk("arst_d2", int'(digit_2), 0);
        chk("arst_gc", int'(guess_correct), 0);
        chk("arst_go", int'(game_over), 0);
        @(negedge master_clk);
        rst = 1'b1;
        last_pos = 3'd7;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 3'd0);
        chk("post_rst_idle_mole", int'(mole_position), 7);
        chk("post_rst_idle_go", int'(game_over), 0);

        @(negedge master_clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
